// File: rtl/vdff_skew_line.sv
// Multi-channel programmable skew/delay register with stall, valid tracking
// and config-load flush, used to re-align data around bypassed PEs.
module vdff_skew_line #(
    parameter int WORD_SIZE     = 16,
    parameter int NUM_CH        = 4,
    parameter int MAX_DELAY     = 4,
    parameter int DEFAULT_DELAY = 0,
    localparam int DW           = $clog2(MAX_DELAY + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        cfg_load,
    input  logic [NUM_CH*DW-1:0]        delay_cfg,
    input  logic                        in_valid,
    input  logic [NUM_CH*WORD_SIZE-1:0] D,
    output logic [NUM_CH*WORD_SIZE-1:0] Q,
    output logic [NUM_CH-1:0]           Q_valid,
    output logic                        busy
);

    logic [WORD_SIZE-1:0] stage [NUM_CH][MAX_DELAY];
    logic [MAX_DELAY-1:0] vbit  [NUM_CH];
    logic [DW-1:0]        delay [NUM_CH];

    logic [WORD_SIZE-1:0] tap_d     [NUM_CH];
    logic                 tap_v     [NUM_CH];
    logic [DW-1:0]        delay_nxt [NUM_CH];

    // Select the output tap per channel; delay 0 bypasses the chain entirely.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            tap_d[c] = D[c*WORD_SIZE +: WORD_SIZE];
            tap_v[c] = in_valid;
            for (int k = 0; k < MAX_DELAY; k++) begin
                if (delay[c] == DW'(k + 1)) begin
                    tap_d[c] = stage[c][k];
                    tap_v[c] = vbit[c][k];
                end
            end
        end
    end

    // Saturate each requested delay field to the chain length.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            delay_nxt[c] = delay_cfg[c*DW +: DW];
            if (delay_cfg[c*DW +: DW] > DW'(MAX_DELAY)) begin
                delay_nxt[c] = DW'(MAX_DELAY);
            end
        end
    end

    // Shift chains and update outputs on en; cfg_load re-programs and flushes valids.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < MAX_DELAY; k++) begin
                    stage[c][k] <= '0;
                end
                vbit[c]  <= '0;
                delay[c] <= DW'(DEFAULT_DELAY);
            end
            Q       <= '0;
            Q_valid <= '0;
        end else begin
            if (en) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    stage[c][0] <= D[c*WORD_SIZE +: WORD_SIZE];
                    for (int k = 1; k < MAX_DELAY; k++) begin
                        stage[c][k] <= stage[c][k-1];
                    end
                    vbit[c] <= (vbit[c] << 1) | MAX_DELAY'(in_valid);
                    Q[c*WORD_SIZE +: WORD_SIZE] <= tap_d[c];
                    Q_valid[c] <= tap_v[c];
                end
            end
            if (cfg_load) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    delay[c]   <= delay_nxt[c];
                    vbit[c]    <= en ? MAX_DELAY'(in_valid) : '0;
                    Q_valid[c] <= 1'b0;
                end
            end
        end
    end

    // Any valid word still travelling through any chain.
    always_comb begin
        busy = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            busy = busy | (|vbit[c]);
        end
    end

endmodule

// File: tb/tb_vdff_skew_line.sv
// Self-checking bench for vdff_skew_line: directed scenarios plus random
// traffic compared against an input-history reference model.
module tb_vdff_skew_line;

    localparam int W   = 16;
    localparam int NC  = 4;
    localparam int MD  = 4;
    localparam int DEF = 0;
    localparam int DW  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              cfg_load = 1'b0;
    logic [NC*DW-1:0]  delay_cfg = '0;
    logic              in_valid = 1'b0;
    logic [NC*W-1:0]   D = '0;
    logic [NC*W-1:0]   Q;
    logic [NC-1:0]     Q_valid;
    logic              busy;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: per channel, the last MD+1 accepted inputs (index 0 newest).
    logic [W-1:0] hd  [NC][MD+1];
    bit           hv  [NC][MD+1];
    int           md  [NC];
    logic [W-1:0] mq  [NC];
    bit           mqv [NC];

    vdff_skew_line #(
        .WORD_SIZE(W), .NUM_CH(NC), .MAX_DELAY(MD), .DEFAULT_DELAY(DEF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load),
        .delay_cfg(delay_cfg), .in_valid(in_valid), .D(D),
        .Q(Q), .Q_valid(Q_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic model_edge();
        int f;
        if (!rst_n) begin
            for (int c = 0; c < NC; c++) begin
                for (int j = 0; j <= MD; j++) begin
                    hd[c][j] = '0;
                    hv[c][j] = 1'b0;
                end
                md[c] = DEF; mq[c] = '0; mqv[c] = 1'b0;
            end
        end else begin
            if (en) begin
                for (int c = 0; c < NC; c++) begin
                    for (int j = MD; j > 0; j--) begin
                        hd[c][j] = hd[c][j-1];
                        hv[c][j] = hv[c][j-1];
                    end
                    hd[c][0] = D[c*W +: W];
                    hv[c][0] = in_valid;
                    mq[c]  = hd[c][md[c]];
                    mqv[c] = hv[c][md[c]];
                end
            end
            if (cfg_load) begin
                for (int c = 0; c < NC; c++) begin
                    for (int j = 0; j <= MD; j++) hv[c][j] = 1'b0;
                    if (en) hv[c][0] = in_valid;
                    mqv[c] = 1'b0;
                    f = int'(delay_cfg[c*DW +: DW]);
                    md[c] = (f > MD) ? MD : f;
                end
            end
        end
    endtask

    task automatic compare();
        logic [NC*W-1:0] eq;
        logic [NC-1:0]   ev;
        logic            eb;
        eb = 1'b0;
        for (int c = 0; c < NC; c++) begin
            eq[c*W +: W] = mq[c];
            ev[c] = mqv[c];
            for (int j = 0; j < MD; j++) eb = eb | hv[c][j];
        end
        chk("Q", 64'(Q), 64'(eq));
        chk("Q_valid", 64'(Q_valid), 64'(ev));
        chk("busy", 64'(busy), 64'(eb));
    endtask

    task automatic step(input logic r, input logic e, input logic cl,
                        input logic [NC*DW-1:0] dc, input logic iv,
                        input logic [NC*W-1:0] d);
        @(negedge clk);
        rst_n = r; en = e; cfg_load = cl;
        delay_cfg = dc; in_valid = iv; D = d;
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    initial begin
        // reset and plain-DFF behaviour at default delay
        step(0, 1, 0, '0, 1, 64'h1234);
        chk("rst_Q", 64'(Q), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        step(1, 1, 0, '0, 1, 64'h1111);
        chk("t1_Q0", 64'(Q[15:0]), 64'h1111);
        chk("t1_V0", 64'(Q_valid[0]), 64'h1);

        // ch0 delay 3, ch1 delay 0, streamed words
        step(1, 1, 1, 12'o0003, 0, '0);
        for (int n = 1; n <= 10; n++) begin
            step(1, 1, 0, '0, 1, {4{16'(n)}});
            chk("t2_Q1", 64'(Q[31:16]), 64'(n));
            if (n > 3) chk("t2_Q0", 64'(Q[15:0]), 64'(n - 3));
        end

        // delay 2 everywhere, stall for 5 cycles
        step(1, 0, 1, 12'o2222, 0, '0);
        step(1, 1, 0, '0, 1, {4{16'hAAAA}});
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, '0, 1, {4{16'h5A5A}});
            chk("t3_hold", 64'(Q_valid), 64'h0);
        end
        step(1, 1, 0, '0, 0, '0);
        chk("t3_early", 64'(Q_valid), 64'h0);
        step(1, 1, 0, '0, 0, '0);
        chk("t3_Q", 64'(Q[15:0]), 64'hAAAA);
        chk("t3_V", 64'(Q_valid), 64'hF);

        // delay 4 with words in flight, then flush to delay 1
        step(1, 1, 1, 12'o4444, 0, '0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, '0, 1, {4{16'(i + 7)}});
        step(1, 1, 1, 12'o1111, 0, '0);
        chk("t4_busy", 64'(busy), 64'h0);
        chk("t4_V", 64'(Q_valid), 64'h0);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, '0, 0, '0);
            chk("t4_stale", 64'(Q_valid), 64'h0);
        end

        // oversize field saturates to MD -> latency MD+1
        step(1, 1, 1, 12'o6666, 0, '0);
        step(1, 1, 0, '0, 1, {4{16'h5555}});
        for (int i = 2; i <= 5; i++) begin
            step(1, 1, 0, '0, 0, '0);
            chk("t5_V", 64'(Q_valid[0]), (i == 5) ? 64'h1 : 64'h0);
        end
        chk("t5_Q", 64'(Q[15:0]), 64'h5555);

        // reset wins over en and cfg_load mid-stream
        step(1, 1, 0, '0, 1, {4{16'hBEEF}});
        step(0, 1, 1, 12'o3333, 1, {4{16'hCAFE}});
        chk("t6_Q", 64'(Q), 64'h0);
        chk("t6_V", 64'(Q_valid), 64'h0);
        step(1, 1, 0, '0, 1, {4{16'h7777}});
        chk("t6_def", 64'(Q[15:0]), 64'h7777);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 100) != 0, ($urandom % 4) != 0,
                 ($urandom % 12) == 0, NC*DW'($urandom), 1'($urandom),
                 {$urandom, $urandom});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
